// File: rtl/ibex_mem_bridge.sv
// rtl/ibex_mem_bridge.sv - Ibex req/gnt/rvalid port to split A/D valid/ready channel bridge
module ibex_mem_bridge #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int REG_RESP        = 0,
    parameter int ERR_CNT_W       = 8,
    localparam int BE_W           = DATA_W / 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 up_req_i,
    output logic                 up_gnt_o,
    input  logic [ADDR_W-1:0]    up_addr_i,
    input  logic                 up_we_i,
    input  logic [BE_W-1:0]      up_be_i,
    input  logic [DATA_W-1:0]    up_wdata_i,
    output logic                 up_rvalid_o,
    output logic [DATA_W-1:0]    up_rdata_o,
    output logic                 up_err_o,
    output logic                 dn_a_valid_o,
    input  logic                 dn_a_ready_i,
    output logic [ADDR_W-1:0]    dn_a_addr_o,
    output logic                 dn_a_we_o,
    output logic [BE_W-1:0]      dn_a_be_o,
    output logic [DATA_W-1:0]    dn_a_wdata_o,
    input  logic                 dn_d_valid_i,
    output logic                 dn_d_ready_o,
    input  logic [DATA_W-1:0]    dn_d_rdata_i,
    input  logic                 dn_d_err_i,
    output logic [CNT_W-1:0]     outstanding_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic                 err_valid_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    output logic                 proto_err_o,
    input  logic                 err_clear_i
);

    // A single-entry FIFO still needs a one-bit pointer that simply stays at zero.
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]    fifo_q [MAX_OUTSTANDING];
    logic [ADDR_W-1:0]    fifo_d [MAX_OUTSTANDING];
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
    logic                 proto_err_q, proto_err_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rerr_q, rerr_d;

    logic full, accept, legal, illegal;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request path is pure pass-through gated only by the outstanding limit.
    always_comb begin
        full         = (count_q == CNT_W'(MAX_OUTSTANDING));
        dn_a_valid_o = up_req_i & ~full;
        accept       = up_req_i & ~full & dn_a_ready_i;
        up_gnt_o     = accept;
        dn_a_addr_o  = up_addr_i;
        dn_a_we_o    = up_we_i;
        dn_a_be_o    = up_be_i;
        dn_a_wdata_o = up_wdata_i;
        dn_d_ready_o = 1'b1;
        legal        = dn_d_valid_i & (count_q != '0);
        illegal      = dn_d_valid_i & (count_q == '0);
    end

    // Next-state for tracking FIFO, error bookkeeping and the optional response register.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        case ({accept, legal})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept) begin
            fifo_d[wr_ptr_q] = up_addr_i;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (legal) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Clear is applied first so that an error in the same cycle still registers.
        err_count_d = err_clear_i ? '0 : err_count_q;
        err_valid_d = err_clear_i ? 1'b0 : err_valid_q;
        proto_err_d = (err_clear_i ? 1'b0 : proto_err_q) | illegal;
        err_addr_d  = err_addr_q;
        if (legal && dn_d_err_i) begin
            if (err_count_d != '1) begin
                err_count_d = err_count_d + 1'b1;
            end
            err_valid_d = 1'b1;
            err_addr_d  = fifo_q[rd_ptr_q];
        end

        rvalid_d = legal;
        rdata_d  = legal ? dn_d_rdata_i : rdata_q;
        rerr_d   = legal & dn_d_err_i;
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_q      <= '{default: '0};
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            proto_err_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_q      <= fifo_d;
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            proto_err_q <= proto_err_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
        end
    end

    assign up_rvalid_o   = (REG_RESP != 0) ? rvalid_q : legal;
    assign up_rdata_o    = (REG_RESP != 0) ? rdata_q  : dn_d_rdata_i;
    assign up_err_o      = (REG_RESP != 0) ? rerr_q   : dn_d_err_i;
    assign outstanding_o = count_q;
    assign err_count_o   = err_count_q;
    assign err_valid_o   = err_valid_q;
    assign err_addr_o    = err_addr_q;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_ibex_mem_bridge.sv
// tb/tb_ibex_mem_bridge.sv - randomized and directed check of ibex_mem_bridge, both response modes
module tb_ibex_mem_bridge;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst, req, we, a_ready, d_valid, d_err, clr;
    logic [31:0] addr, wdata, d_rdata;
    logic [3:0]  be;

    logic        gnt0, rv0, er0, av0, awe0, drdy0, ev0, pe0;
    logic [31:0] rd0, aaddr0, awd0, eaddr0;
    logic [3:0]  abe0;
    logic [1:0]  out0;
    logic [7:0]  ecnt0;

    logic        gnt1, rv1, er1, av1, awe1, drdy1, ev1, pe1;
    logic [31:0] rd1, aaddr1, awd1, eaddr1;
    logic [3:0]  abe1;
    logic [1:0]  out1;
    logic [7:0]  ecnt1;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] mq[$];
    int          m_ecnt;
    bit          m_ev, m_perr, m_rv, m_rerr;
    logic [31:0] m_eaddr, m_rdata;

    always #5 clk = ~clk;

    ibex_mem_bridge #(.MAX_OUTSTANDING(MAXO), .REG_RESP(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .up_req_i(req), .up_gnt_o(gnt0), .up_addr_i(addr),
        .up_we_i(we), .up_be_i(be), .up_wdata_i(wdata), .up_rvalid_o(rv0), .up_rdata_o(rd0),
        .up_err_o(er0), .dn_a_valid_o(av0), .dn_a_ready_i(a_ready), .dn_a_addr_o(aaddr0),
        .dn_a_we_o(awe0), .dn_a_be_o(abe0), .dn_a_wdata_o(awd0), .dn_d_valid_i(d_valid),
        .dn_d_ready_o(drdy0), .dn_d_rdata_i(d_rdata), .dn_d_err_i(d_err), .outstanding_o(out0),
        .err_count_o(ecnt0), .err_valid_o(ev0), .err_addr_o(eaddr0), .proto_err_o(pe0),
        .err_clear_i(clr));

    ibex_mem_bridge #(.MAX_OUTSTANDING(MAXO), .REG_RESP(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .up_req_i(req), .up_gnt_o(gnt1), .up_addr_i(addr),
        .up_we_i(we), .up_be_i(be), .up_wdata_i(wdata), .up_rvalid_o(rv1), .up_rdata_o(rd1),
        .up_err_o(er1), .dn_a_valid_o(av1), .dn_a_ready_i(a_ready), .dn_a_addr_o(aaddr1),
        .dn_a_we_o(awe1), .dn_a_be_o(abe1), .dn_a_wdata_o(awd1), .dn_d_valid_i(d_valid),
        .dn_d_ready_o(drdy1), .dn_d_rdata_i(d_rdata), .dn_d_err_i(d_err), .outstanding_o(out1),
        .err_count_o(ecnt1), .err_valid_o(ev1), .err_addr_o(eaddr1), .proto_err_o(pe1),
        .err_clear_i(clr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int  n;
        bit  eg, legal;
        n     = mq.size();
        eg    = req && (n != MAXO) && a_ready;
        legal = d_valid && (n != 0);
        chk("gnt0", gnt0, eg);
        chk("gnt1", gnt1, eg);
        chk("a_valid0", av0, req && (n != MAXO));
        chk("a_valid1", av1, req && (n != MAXO));
        chk("a_fields0", {awe0, abe0, awd0, aaddr0}, {we, be, wdata, addr});
        chk("a_fields1", {awe1, abe1, awd1, aaddr1}, {we, be, wdata, addr});
        chk("d_ready", {drdy0, drdy1}, 2'b11);
        chk("rvalid0", rv0, legal);
        if (legal) chk("rdata0", {er0, rd0}, {d_err, d_rdata});
        chk("rvalid1", rv1, m_rv);
        if (m_rv) chk("rdata1", {er1, rd1}, {m_rerr, m_rdata});
        chk("outstanding0", out0, n);
        chk("outstanding1", out1, n);
        chk("err_count0", ecnt0, m_ecnt);
        chk("err_count1", ecnt1, m_ecnt);
        chk("err_valid", {ev0, ev1}, {m_ev, m_ev});
        chk("err_addr0", eaddr0, m_eaddr);
        chk("err_addr1", eaddr1, m_eaddr);
        chk("proto_err", {pe0, pe1}, {m_perr, m_perr});
    endtask

    task automatic model_edge();
        int          n;
        bit          eg, legal;
        logic [31:0] h;
        if (rst) begin
            mq.delete();
            m_ecnt = 0; m_ev = 0; m_eaddr = 0; m_perr = 0; m_rv = 0;
            return;
        end
        n     = mq.size();
        eg    = req && (n != MAXO) && a_ready;
        legal = d_valid && (n != 0);
        m_rv  = legal;
        if (legal) begin
            m_rdata = d_rdata;
            m_rerr  = d_err;
        end
        if (clr) begin
            m_ecnt = 0; m_ev = 0; m_perr = 0;
        end
        if (legal) begin
            h = mq.pop_front();
            if (d_err) begin
                if (m_ecnt < 255) m_ecnt++;
                m_eaddr = h;
                m_ev    = 1;
            end
        end
        if (d_valid && n == 0) m_perr = 1;
        if (eg) mq.push_back(addr);
    endtask

    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; req = 0; addr = 0; we = 0; be = 0; wdata = 0;
        a_ready = 1; d_valid = 0; d_rdata = 0; d_err = 0; clr = 0;
    endtask

    task automatic set_req(input logic [31:0] a);
        req = 1; addr = a; we = $urandom_range(0, 1); be = 4'($urandom); wdata = $urandom;
    endtask

    task automatic set_resp(input logic [31:0] data, input logic e);
        d_valid = 1; d_rdata = data; d_err = e;
    endtask

    initial begin
        m_ecnt = 0; m_ev = 0; m_eaddr = 0; m_perr = 0; m_rv = 0; m_rdata = 0; m_rerr = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        tick();

        // single read
        set_req(32'h1000); tick();
        idle(); tick();
        set_resp(32'hDEADBEEF, 0); tick();
        idle(); tick();

        // back-pressure then full: third request held until a response drains one slot
        a_ready = 0; set_req(32'hA0); tick(); tick();
        a_ready = 1; tick();
        set_req(32'hA4); tick();
        set_req(32'hA8); tick(); tick();
        set_resp(32'h1, 0); tick();
        d_valid = 0; tick();
        idle(); set_resp(32'h2, 0); tick(); tick();
        idle(); tick();

        // error capture on the second of two responses
        set_req(32'h2000); tick();
        set_req(32'h2004); tick();
        idle(); set_resp(32'h11, 0); tick();
        set_resp(32'h22, 1); tick();
        idle(); tick();

        // illegal response, then clear coincident with a new error
        set_resp(32'h33, 0); tick();
        idle(); tick();
        set_req(32'h3000); tick();
        idle(); tick();
        set_resp(32'h44, 1); clr = 1; tick();
        idle(); tick();
        clr = 1; set_resp(32'h55, 0); tick();
        idle(); tick();

        // simultaneous accept and response at count 1; pointers wrap many times
        set_req(32'h4000); tick();
        for (int i = 1; i <= 10; i++) begin
            set_req(32'h4000 + 32'(i * 4));
            set_resp(32'(i), (i % 3) == 0);
            tick();
        end
        idle(); set_resp(32'h66, 1); tick();
        idle(); tick();

        // error counter saturation
        clr = 1; tick(); clr = 0;
        set_req(32'h5000); tick();
        for (int i = 0; i < 300; i++) begin
            set_req(32'h5000 + 32'(i));
            set_resp($urandom, 1);
            tick();
        end
        idle(); set_resp(32'h77, 1); tick();
        idle(); tick();

        // registered read and reset with two outstanding, then a late response
        set_req(32'h6000); tick();
        idle(); set_resp(32'h12345678, 0); tick();
        idle(); tick();
        set_req(32'h6004); tick();
        set_req(32'h6008); tick();
        idle(); rst = 1; tick();
        rst = 0; tick();
        set_resp(32'h88, 0); tick();
        idle(); tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            req     = ($urandom_range(0, 3) != 0);
            addr    = $urandom; we = $urandom_range(0, 1); be = 4'($urandom); wdata = $urandom;
            a_ready = ($urandom_range(0, 3) != 0);
            d_valid = ($urandom_range(0, 2) == 0);
            d_rdata = $urandom;
            d_err   = ($urandom_range(0, 5) == 0);
            clr     = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
